// File: rtl/mem_atomic_ctrl.sv
// MEM-stage memory controller with LL/SC atomics: issues single-word bus
// transactions, tracks the link address and reports results to the pipeline.
module mem_atomic_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        op_valid_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        LLbit_i,
    input  logic        wb_LLbit_we_i,
    input  logic        wb_LLbit_value_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        LLbit_we_o,
    output logic        LLbit_value_o,
    output logic        stallreq_o,
    output logic        bus_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_LW = 2'b00;
    localparam logic [1:0] OP_SW = 2'b01;
    localparam logic [1:0] OP_LL = 2'b10;
    localparam logic [1:0] OP_SC = 2'b11;
    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] link_addr_q, link_addr_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rdata_valid_q, rdata_valid_d;
    logic        llbit_we_q, llbit_we_d;
    logic        llbit_value_q, llbit_value_d;
    logic        bus_err_q, bus_err_d;

    logic eff_llbit;
    logic sc_fail;

    // The WB-stage LLbit write has not landed in the register yet, so bypass it.
    assign eff_llbit = wb_LLbit_we_i ? wb_LLbit_value_i : LLbit_i;
    assign sc_fail   = (op_i == OP_SC) && (!eff_llbit || (addr_i != link_addr_q));

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        cnt_d         = cnt_q;
        link_addr_d   = link_addr_q;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_wdata_d   = bus_wdata_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        llbit_we_d    = 1'b0;
        llbit_value_d = 1'b0;
        bus_err_d     = 1'b0;

        if (flush_i) begin
            state_d   = ST_IDLE;
            bus_req_d = 1'b0;
            cnt_d     = 8'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (op_valid_i) begin
                        op_d        = op_i;
                        bus_addr_d  = addr_i;
                        bus_wdata_d = wdata_i;
                        bus_we_d    = op_i[0];
                        cnt_d       = 8'd0;
                        if (sc_fail) begin
                            state_d   = ST_DONE;
                            rdata_d   = 32'd0;
                            bus_req_d = 1'b0;
                        end else begin
                            state_d   = ST_BUS;
                            bus_req_d = 1'b1;
                        end
                    end
                end
                ST_BUS: begin
                    // An ack in the final wait cycle still wins over the timeout.
                    if (bus_ack_i) begin
                        state_d   = ST_DONE;
                        bus_req_d = 1'b0;
                        cnt_d     = 8'd0;
                        case (op_q)
                            OP_LW, OP_LL: rdata_d = bus_rdata_i;
                            OP_SC:        rdata_d = 32'd1;
                            default:      rdata_d = 32'd0;
                        endcase
                    end else if ((cnt_q + 8'd1) == TIMEOUT_CNT) begin
                        state_d   = ST_IDLE;
                        bus_req_d = 1'b0;
                        bus_err_d = 1'b1;
                        cnt_d     = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_DONE: begin
                    state_d       = ST_IDLE;
                    rdata_valid_d = 1'b1;
                    if (op_q == OP_LL) begin
                        llbit_we_d    = 1'b1;
                        llbit_value_d = 1'b1;
                        link_addr_d   = bus_addr_q;
                    end else if (op_q == OP_SC) begin
                        llbit_we_d    = 1'b1;
                        llbit_value_d = 1'b0;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    bus_req_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            op_q          <= OP_LW;
            cnt_q         <= 8'd0;
            link_addr_q   <= 32'd0;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= 32'd0;
            bus_wdata_q   <= 32'd0;
            rdata_q       <= 32'd0;
            rdata_valid_q <= 1'b0;
            llbit_we_q    <= 1'b0;
            llbit_value_q <= 1'b0;
            bus_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            cnt_q         <= cnt_d;
            link_addr_q   <= link_addr_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_wdata_q   <= bus_wdata_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            llbit_we_q    <= llbit_we_d;
            llbit_value_q <= llbit_value_d;
            bus_err_q     <= bus_err_d;
        end
    end

    assign bus_req_o     = bus_req_q;
    assign bus_we_o      = bus_we_q;
    assign bus_addr_o    = bus_addr_q;
    assign bus_wdata_o   = bus_wdata_q;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rdata_valid_q;
    assign LLbit_we_o    = llbit_we_q;
    assign LLbit_value_o = llbit_value_q;
    assign bus_err_o     = bus_err_q;

    // Stall is combinational so the pipeline freezes in the same cycle an op arrives.
    assign stallreq_o = ((state_q == ST_IDLE) && op_valid_i && !flush_i) ||
                        (state_q == ST_BUS);

endmodule

// File: tb/tb_mem_atomic_ctrl.sv
// Directed bench for mem_atomic_ctrl: LL/SC/LW/SW flows, LLbit bypass,
// bus timeout, flush and reset behaviour, checked with immediate assertions.
module tb_mem_atomic_ctrl;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic        op_valid_i;
    logic [1:0]  op_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        LLbit_i;
    logic        wb_LLbit_we_i;
    logic        wb_LLbit_value_i;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;
    logic [31:0] rdata_o;
    logic        rdata_valid_o;
    logic        LLbit_we_o;
    logic        LLbit_value_o;
    logic        stallreq_o;
    logic        bus_err_o;

    int checks;
    int errors;
    logic [31:0] last_rdata;

    mem_atomic_ctrl #(.TIMEOUT(4)) dut (
        .clk              (clk),
        .rst              (rst),
        .flush_i          (flush_i),
        .op_valid_i       (op_valid_i),
        .op_i             (op_i),
        .addr_i           (addr_i),
        .wdata_i          (wdata_i),
        .LLbit_i          (LLbit_i),
        .wb_LLbit_we_i    (wb_LLbit_we_i),
        .wb_LLbit_value_i (wb_LLbit_value_i),
        .bus_req_o        (bus_req_o),
        .bus_we_o         (bus_we_o),
        .bus_addr_o       (bus_addr_o),
        .bus_wdata_o      (bus_wdata_o),
        .bus_ack_i        (bus_ack_i),
        .bus_rdata_i      (bus_rdata_i),
        .rdata_o          (rdata_o),
        .rdata_valid_o    (rdata_valid_o),
        .LLbit_we_o       (LLbit_we_o),
        .LLbit_value_o    (LLbit_value_o),
        .stallreq_o       (stallreq_o),
        .bus_err_o        (bus_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One complete op; ack_wait = BUS cycles without ack before the ack cycle.
    task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic exp_bus, input int ack_wait,
                         input logic [31:0] rbus, input logic [31:0] exp_rdata,
                         input logic exp_llwe, input logic exp_llval);
        op_i       = op;
        addr_i     = addr;
        wdata_i    = wdata;
        op_valid_i = 1'b1;
        #1;
        check({name, "_stall_accept"}, 32'(stallreq_o), 32'd1);
        tick();
        op_valid_i = 1'b0;
        if (exp_bus) begin
            check({name, "_bus_req"},   32'(bus_req_o), 32'd1);
            check({name, "_bus_we"},    32'(bus_we_o), 32'(op[0]));
            check({name, "_bus_addr"},  bus_addr_o, addr);
            check({name, "_bus_wdata"}, bus_wdata_o, wdata);
            for (int i = 0; i < ack_wait; i++) begin
                tick();
                check({name, "_bus_hold"}, 32'(bus_req_o), 32'd1);
                check({name, "_addr_hold"}, bus_addr_o, addr);
                check({name, "_stall_bus"}, 32'(stallreq_o), 32'd1);
            end
            bus_ack_i   = 1'b1;
            bus_rdata_i = rbus;
            tick();
            bus_ack_i   = 1'b0;
            bus_rdata_i = 32'hFFFF_FFFF;
        end
        check({name, "_no_req_done"}, 32'(bus_req_o), 32'd0);
        check({name, "_stall_done"},  32'(stallreq_o), 32'd0);
        check({name, "_valid_early"}, 32'(rdata_valid_o), 32'd0);
        tick();
        check({name, "_valid"},    32'(rdata_valid_o), 32'd1);
        check({name, "_rdata"},    rdata_o, exp_rdata);
        check({name, "_llbit_we"}, 32'(LLbit_we_o), 32'(exp_llwe));
        if (exp_llwe)
            check({name, "_llbit_val"}, 32'(LLbit_value_o), 32'(exp_llval));
        tick();
        check({name, "_valid_pulse"}, 32'(rdata_valid_o), 32'd0);
        check({name, "_llwe_pulse"},  32'(LLbit_we_o), 32'd0);
        last_rdata = exp_rdata;
    endtask

    initial begin
        checks           = 0;
        errors           = 0;
        last_rdata       = 32'd0;
        rst              = 1'b0;
        flush_i          = 1'b0;
        op_valid_i       = 1'b0;
        op_i             = 2'b00;
        addr_i           = 32'd0;
        wdata_i          = 32'd0;
        LLbit_i          = 1'b0;
        wb_LLbit_we_i    = 1'b0;
        wb_LLbit_value_i = 1'b0;
        bus_ack_i        = 1'b0;
        bus_rdata_i      = 32'd0;

        #12;
        check("rst_bus_req",  32'(bus_req_o), 32'd0);
        check("rst_rdata",    rdata_o, 32'd0);
        check("rst_valid",    32'(rdata_valid_o), 32'd0);
        check("rst_llwe",     32'(LLbit_we_o), 32'd0);
        check("rst_bus_err",  32'(bus_err_o), 32'd0);
        check("rst_stall",    32'(stallreq_o), 32'd0);
        check("rst_bus_addr", bus_addr_o, 32'd0);
        rst = 1'b1;
        tick();

        // LL, ack in third BUS cycle
        do_op("ll100", 2'b10, 32'h100, 32'h0, 1'b1, 2, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1, 1'b1);
        // SC matching link with LLbit set, ack in first BUS cycle
        LLbit_i = 1'b1;
        do_op("sc_ok", 2'b11, 32'h100, 32'hCAFE_F00D, 1'b1, 0, 32'h1234_5678, 32'd1, 1'b1, 1'b0);
        do_op("lw200", 2'b00, 32'h200, 32'h0, 1'b1, 1, 32'hA5A5_0001, 32'hA5A5_0001, 1'b0, 1'b0);
        // SC to a different address than the link fails without bus access
        do_op("sc_addr_fail", 2'b11, 32'h104, 32'h1111, 1'b0, 0, 32'h0, 32'd0, 1'b1, 1'b0);
        // LLbit register clear but WB bypass supplies 1
        LLbit_i = 1'b0; wb_LLbit_we_i = 1'b1; wb_LLbit_value_i = 1'b1;
        do_op("sc_byp_ok", 2'b11, 32'h100, 32'h2222, 1'b1, 0, 32'h0, 32'd1, 1'b1, 1'b0);
        wb_LLbit_we_i = 1'b0; wb_LLbit_value_i = 1'b0;
        // SW acked in the last cycle before timeout
        do_op("sw300", 2'b01, 32'h300, 32'h55AA, 1'b1, 3, 32'hBAD, 32'd0, 1'b0, 1'b0);
        do_op("lw204", 2'b00, 32'h204, 32'h0, 1'b1, 0, 32'h7, 32'h7, 1'b0, 1'b0);
        // LLbit register set but WB bypass supplies 0
        LLbit_i = 1'b1; wb_LLbit_we_i = 1'b1; wb_LLbit_value_i = 1'b0;
        do_op("sc_byp_fail", 2'b11, 32'h100, 32'h3333, 1'b0, 0, 32'h0, 32'd0, 1'b1, 1'b0);
        wb_LLbit_we_i = 1'b0;

        // Timeout: no ack for 4 BUS cycles
        op_i = 2'b00; addr_i = 32'h400; op_valid_i = 1'b1;
        tick();
        op_valid_i = 1'b0;
        check("to_req", 32'(bus_req_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("to_req_hold", 32'(bus_req_o), 32'd1);
            check("to_no_err",   32'(bus_err_o), 32'd0);
        end
        tick();
        check("to_req_drop", 32'(bus_req_o), 32'd0);
        check("to_err",      32'(bus_err_o), 32'd1);
        check("to_stall",    32'(stallreq_o), 32'd0);
        check("to_valid",    32'(rdata_valid_o), 32'd0);
        tick();
        check("to_err_pulse", 32'(bus_err_o), 32'd0);
        check("to_valid2",    32'(rdata_valid_o), 32'd0);
        check("to_llwe",      32'(LLbit_we_o), 32'd0);
        check("to_rdata",     rdata_o, last_rdata);

        // Flush in IDLE blocks acceptance
        op_i = 2'b10; addr_i = 32'h600; op_valid_i = 1'b1; flush_i = 1'b1;
        #1;
        check("fl_idle_stall", 32'(stallreq_o), 32'd0);
        tick();
        op_valid_i = 1'b0; flush_i = 1'b0;
        check("fl_idle_req", 32'(bus_req_o), 32'd0);
        tick();
        check("fl_idle_valid", 32'(rdata_valid_o), 32'd0);

        // Flush coincident with ack during BUS
        op_i = 2'b10; addr_i = 32'h500; op_valid_i = 1'b1;
        tick();
        op_valid_i = 1'b0;
        check("fl_req", 32'(bus_req_o), 32'd1);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h0BAD_F00D; flush_i = 1'b1;
        tick();
        bus_ack_i = 1'b0; flush_i = 1'b0;
        check("fl_req_drop", 32'(bus_req_o), 32'd0);
        check("fl_stall",    32'(stallreq_o), 32'd0);
        check("fl_valid",    32'(rdata_valid_o), 32'd0);
        check("fl_llwe",     32'(LLbit_we_o), 32'd0);
        tick();
        check("fl_valid2", 32'(rdata_valid_o), 32'd0);
        check("fl_llwe2",  32'(LLbit_we_o), 32'd0);
        check("fl_rdata",  rdata_o, last_rdata);
        // Link must still be 0x100, so an SC to 0x500 fails
        LLbit_i = 1'b1;
        do_op("sc_after_flush", 2'b11, 32'h500, 32'h4444, 1'b0, 0, 32'h0, 32'd0, 1'b1, 1'b0);

        // Asynchronous reset mid-BUS
        op_i = 2'b00; addr_i = 32'h700; op_valid_i = 1'b1;
        tick();
        op_valid_i = 1'b0;
        check("ar_req", 32'(bus_req_o), 32'd1);
        rst = 1'b0;
        #1;
        check("ar_req_drop", 32'(bus_req_o), 32'd0);
        check("ar_stall",    32'(stallreq_o), 32'd0);
        check("ar_addr",     bus_addr_o, 32'd0);
        #1;
        rst = 1'b1;
        tick();
        check("ar_req_after", 32'(bus_req_o), 32'd0);
        check("ar_valid",     32'(rdata_valid_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
